writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: alu_valid  input  1 / alu_rd  input  5 / alu_data  input  32  ALU result, one-cycle pulse.
REQ-004 SHALL have ports: ld_issue  input  1 / ld_rd  input  5 / ld_funct3  input  3 / ld_addr_lo  input  2  load issue, one-cycle pulse.
REQ-005 SHALL have ports: mem_rvalid  input  1 / mem_rdata  input  32 / mem_rready  output  1  load response handshake.
REQ-006 SHALL have ports: rs1  input  5 / rs2  input  5  decode-stage source registers; stall  output  1  hazard stall.
REQ-007 SHALL have ports: wr_req  output  1 / wr_rd  output  5 / wr_data  output  32  register-file write port, all registered.
REQ-008 SHALL have ports: ld_busy  output  1  load outstanding; err  output  1  sticky protocol-error flag.

Function
REQ-009 SHALL track at most one outstanding load: pending rd, funct3, addr_lo, busy bit.
REQ-010 SHALL capture ld_issue when busy=0, or busy=1 with response accepted same cycle; busy=1 next cycle.
REQ-011 SHALL ignore ld_issue when busy=1 and no response accepted that cycle; set err=1 (sticky until reset).
REQ-012 SHALL drive mem_rready = busy AND NOT alu_valid (combinational); ALU has priority, memory response waits.
REQ-013 SHALL accept response when mem_rvalid AND mem_rready; clear busy next cycle unless REQ-010 re-arms it.
REQ-014 SHALL register write one cycle after event: ALU: wr_rd=alu_rd, wr_data=alu_data; load: wr_rd=pending rd, wr_data=extended data.
REQ-015 SHALL hold wr_req=1 for exactly one cycle per write; wr_req=0 if target rd=0 (load still retires, busy clears).
REQ-016 SHALL hold wr_rd/wr_data at last values when wr_req=0.
REQ-017 SHALL extract byte = mem_rdata[8*addr_lo+7 : 8*addr_lo]; halfword = mem_rdata[16*addr_lo[1]+15 : 16*addr_lo[1]] (addr_lo[0] ignored).
REQ-018 SHALL extend per funct3: 0 LB sign byte; 1 LH sign half; 2 LW full word; 4 LBU zero byte; 5 LHU zero half; 3/6/7 full word, err=1.
REQ-019 SHALL assert stall = busy AND pending rd!=0 AND (rs1==pending rd OR rs2==pending rd); combinational.
REQ-020 SHALL deassert stall the cycle after the response is accepted (retiring write then visible via wr_* port).
REQ-021 SHALL never drop an ALU result; back-to-back alu_valid every cycle yields wr_req every cycle, load deferred.
REQ-022 ld_busy SHALL equal busy bit.

Reset
REQ-023 SHALL on reset: wr_req=0, wr_rd=0, wr_data=0, busy=0, err=0, pending fields=0; mem_rready=0, stall=0.
REQ-024 SHALL abandon an outstanding load on reset mid-operation; a later mem_rvalid SHALL NOT produce a write.

Verification
REQ-025 ALU: alu_valid, rd=5, data=0x1234 at cycle N -> wr_req=1, wr_rd=5, wr_data=0x1234 at N+1 only.
REQ-026 LB: issue rd=10, funct3=0, addr_lo=2; rdata=0x00800000 -> wr_data=0xFFFFFF80 on rd 10; LBU same -> 0x00000080.
REQ-027 Conflict: load response valid with alu_valid 3 cycles -> mem_rready=0 those cycles, 3 ALU writes, then load write; no loss.
REQ-028 Hazard: pending rd=7, rs2=7 -> stall=1 until acceptance cycle; rs1=rs2=0 with pending rd=0 -> stall=0.
REQ-029 Protocol: second ld_issue while busy -> ignored, err=1; funct3=3 -> full word written, err=1.
REQ-030 Reset: assert reset with busy=1 -> busy=0, err=0 immediately; subsequent mem_rvalid -> wr_req stays 0.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and a single outstanding load into one
// register-file write port, with load extension, hazard stall and protocol-error flag.
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_rready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic        wr_req,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic        ld_busy,
  output logic        err
);

  logic        busy_r;
  logic [4:0]  pend_rd_r;
  logic [2:0]  pend_f3_r;
  logic [1:0]  pend_lo_r;
  logic        err_r;
  logic        wr_req_r;
  logic [4:0]  wr_rd_r;
  logic [31:0] wr_data_r;

  logic        accept_s;
  logic        take_s;
  logic        drop_s;
  logic        bad_f3_s;
  logic        hazard_s;
  logic [31:0] ld_data_s;

  // Unsupported funct3 codes (3/6/7) fall through to the full word.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lo +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    load_extend = {{24{b[7]}}, b};
      3'd1:    load_extend = {{16{h[15]}}, h};
      3'd4:    load_extend = {24'd0, b};
      3'd5:    load_extend = {16'd0, h};
      default: load_extend = rdata;
    endcase
  endfunction

  // Handshake, issue arbitration and hazard detection.
  always_comb begin
    accept_s  = mem_rvalid & busy_r & ~alu_valid;
    take_s    = ld_issue & (~busy_r | accept_s);
    drop_s    = ld_issue & busy_r & ~accept_s;
    bad_f3_s  = (pend_f3_r == 3'd3) | (pend_f3_r == 3'd6) | (pend_f3_r == 3'd7);
    ld_data_s = load_extend(pend_f3_r, pend_lo_r, mem_rdata);
    if (busy_r && (pend_rd_r != 5'd0)) begin
      hazard_s = (rs1 == pend_rd_r) | (rs2 == pend_rd_r);
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Pending-load tracking, sticky error and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r    <= 1'b0;
      pend_rd_r <= 5'd0;
      pend_f3_r <= 3'd0;
      pend_lo_r <= 2'd0;
      err_r     <= 1'b0;
      wr_req_r  <= 1'b0;
      wr_rd_r   <= 5'd0;
      wr_data_r <= 32'd0;
    end else begin
      // ALU wins the port; a ready response simply waits because mem_rready is low.
      if (alu_valid) begin
        wr_req_r <= (alu_rd != 5'd0);
        if (alu_rd != 5'd0) begin
          wr_rd_r   <= alu_rd;
          wr_data_r <= alu_data;
        end
      end else if (accept_s) begin
        wr_req_r <= (pend_rd_r != 5'd0);
        if (pend_rd_r != 5'd0) begin
          wr_rd_r   <= pend_rd_r;
          wr_data_r <= ld_data_s;
        end
      end else begin
        wr_req_r <= 1'b0;
      end

      if (take_s) begin
        busy_r    <= 1'b1;
        pend_rd_r <= ld_rd;
        pend_f3_r <= ld_funct3;
        pend_lo_r <= ld_addr_lo;
      end else if (accept_s) begin
        busy_r <= 1'b0;
      end

      if (drop_s || (accept_s && bad_f3_s)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign mem_rready = busy_r & ~alu_valid;
  assign stall      = hazard_s;
  assign wr_req     = wr_req_r;
  assign wr_rd      = wr_rd_r;
  assign wr_data    = wr_data_r;
  assign ld_busy    = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit, checked against a
// transaction-level model of the pending load and the write port.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_rd = 5'd0;
  logic [2:0]  ld_funct3 = 3'd0;
  logic [1:0]  ld_addr_lo = 2'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rready;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic        stall;
  logic        wr_req;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        ld_busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Model: one pending-load record plus the last observable write.
  logic        m_busy = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [2:0]  m_f3 = 3'd0;
  logic [1:0]  m_lo = 2'd0;
  logic        m_err = 1'b0;
  logic        m_wr_req = 1'b0;
  logic [4:0]  m_wr_rd = 5'd0;
  logic [31:0] m_wr_data = 32'd0;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .wr_req(wr_req), .wr_rd(wr_rd), .wr_data(wr_data),
    .ld_busy(ld_busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Load result by arithmetic: shift the lane down, mask, add sign fill.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * lo)) % 256;
    h = (d >> (16 * (lo / 2))) % 65536;
    case (f3)
      3'd0:    return (b < 128) ? b : b + 32'hFFFF_FF00;
      3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic li, input logic [4:0] lrd, input logic [2:0] lf3,
                      input logic [1:0] llo, input logic rv, input logic [31:0] rdat,
                      input logic [4:0] r1, input logic [4:0] r2, input logic rst_i);
    logic exp_rdy, exp_stall, acc;
    @(negedge clk);
    check_val("wr_req", {31'd0, wr_req}, {31'd0, m_wr_req});
    check_val("wr_rd", {27'd0, wr_rd}, {27'd0, m_wr_rd});
    check_val("wr_data", wr_data, m_wr_data);
    check_val("ld_busy", {31'd0, ld_busy}, {31'd0, m_busy});
    check_val("err", {31'd0, err}, {31'd0, m_err});
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue = li; ld_rd = lrd; ld_funct3 = lf3; ld_addr_lo = llo;
    mem_rvalid = rv; mem_rdata = rdat; rs1 = r1; rs2 = r2; reset = rst_i;
    #1;
    if (rst_i) begin
      m_busy = 1'b0; m_rd = 5'd0; m_f3 = 3'd0; m_lo = 2'd0; m_err = 1'b0;
      m_wr_req = 1'b0; m_wr_rd = 5'd0; m_wr_data = 32'd0;
      check_val("rst_busy", {31'd0, ld_busy}, 32'd0);
      check_val("rst_err", {31'd0, err}, 32'd0);
      check_val("rst_wr", {26'd0, wr_req, wr_rd}, 32'd0);
      check_val("rst_data", wr_data, 32'd0);
      check_val("rst_rdy_stall", {30'd0, mem_rready, stall}, 32'd0);
    end else begin
      exp_rdy = m_busy && !av;
      exp_stall = m_busy && (m_rd != 5'd0) && ((r1 == m_rd) || (r2 == m_rd));
      check_val("mem_rready", {31'd0, mem_rready}, {31'd0, exp_rdy});
      check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
      acc = rv && exp_rdy;
      m_wr_req = 1'b0;
      if (av) begin
        if (ard != 5'd0) begin
          m_wr_req = 1'b1; m_wr_rd = ard; m_wr_data = ad;
        end
      end else if (acc) begin
        if (m_rd != 5'd0) begin
          m_wr_req = 1'b1; m_wr_rd = m_rd; m_wr_data = ref_load(m_f3, m_lo, rdat);
        end
        if (m_f3 == 3'd3 || m_f3 >= 3'd6) m_err = 1'b1;
      end
      if (li && (!m_busy || acc)) begin
        m_busy = 1'b1; m_rd = lrd; m_f3 = lf3; m_lo = llo;
      end else begin
        if (li) m_err = 1'b1;
        if (acc) m_busy = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, r1, r2, 1'b0);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b1);
    idle(5'd0, 5'd0);

    // ALU write visible for exactly one cycle
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("alu_pulse", {26'd0, wr_req, wr_rd}, {26'd0, 1'b1, 5'd5});
    check_val("alu_data", wr_data, 32'h1234);
    idle(5'd0, 5'd0);
    after_edge();
    check_val("alu_one_cycle", {31'd0, wr_req}, 32'd0);

    // LB / LBU on byte lane 2
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 3'd0, 2'd2, 1'b0, 32'd0, 5'd0, 5'd10, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h0080_0000, 5'd0, 5'd10, 1'b0);
    after_edge();
    check_val("lb_data", wr_data, 32'hFFFF_FF80);
    check_val("lb_rd", {27'd0, wr_rd}, 32'd10);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 3'd4, 2'd2, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h0080_0000, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("lbu_data", wr_data, 32'h0000_0080);

    // Response held off by three ALU writes, then retires
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 3'd2, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 1; i <= 3; i++)
      step(1'b1, 5'(i), 32'(i * 17), 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'hCAFE_F00D, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'hCAFE_F00D, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("deferred_load", wr_data, 32'hCAFE_F00D);

    // Hazard on rs2 until acceptance; rd=0 pending never stalls
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'd1, 2'd3, 1'b0, 32'd0, 5'd0, 5'd7, 1'b0);
    idle(5'd0, 5'd7);
    check_val("hazard_stall", {31'd0, stall}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h8001_0000, 5'd0, 5'd7, 1'b0);
    idle(5'd0, 5'd7);
    check_val("hazard_clear", {31'd0, stall}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 3'd2, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    idle(5'd0, 5'd0);
    check_val("rd0_no_stall", {31'd0, stall}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h1111_1111, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("rd0_no_write", {31'd0, wr_req}, 32'd0);

    // Double issue and bad funct3 both raise err
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 3'd2, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("double_issue_err", {31'd0, err}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 3'd3, 2'd1, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h89AB_CDEF, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("bad_f3_word", wr_data, 32'h89AB_CDEF);
    check_val("bad_f3_err", {31'd0, err}, 32'd1);

    // Reset abandons an outstanding load
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 3'd2, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h5555_5555, 5'd0, 5'd0, 1'b0);
    after_edge();
    check_val("no_write_after_rst", {31'd0, wr_req}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 30, 5'($urandom % 8), $urandom,
           ($urandom % 100) < 25, 5'($urandom % 8), 3'($urandom % 8), 2'($urandom % 4),
           ($urandom % 100) < 50, $urandom,
           5'($urandom % 8), 5'($urandom % 8), ($urandom % 64) == 0);
    end
    idle(5'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
